// File: rtl/pio_init_pkg.sv
// Shared definitions for the addressed 32-bit parameter-word protocol.
// Used by both the transmitter (pio_init_sequencer) and the receiving
// decoder so both ends agree on the address map and word layout.
//   Word layout: [31:24] addr, [23:DATA] zero pad, [17:0] data.
package pio_init_pkg;

    localparam int unsigned PIO_WORD_W = 32;
    localparam int unsigned PIO_ADDR_W = 8;
    localparam int unsigned PIO_DATA_W = 18;
    localparam int unsigned PIO_PAD_W  = PIO_WORD_W - PIO_ADDR_W - PIO_DATA_W;

    // Address map
    localparam logic [PIO_ADDR_W-1:0] ADDR_IDLE  = 8'd0;
    localparam logic [PIO_ADDR_W-1:0] ADDR_START = 8'd1;
    localparam logic [PIO_ADDR_W-1:0] ADDR_K1    = 8'd2;
    localparam logic [PIO_ADDR_W-1:0] ADDR_K2    = 8'd3;
    localparam logic [PIO_ADDR_W-1:0] ADDR_KM    = 8'd4;
    localparam logic [PIO_ADDR_W-1:0] ADDR_X1    = 8'd5;
    localparam logic [PIO_ADDR_W-1:0] ADDR_V1    = 8'd6;
    localparam logic [PIO_ADDR_W-1:0] ADDR_X2    = 8'd7;
    localparam logic [PIO_ADDR_W-1:0] ADDR_V2    = 8'd8;

    // Sequencer state encoding
    localparam int unsigned    STATE_W  = 2;
    localparam logic [1:0]     ST_IDLE  = 2'd0;
    localparam logic [1:0]     ST_SEND  = 2'd1;
    localparam logic [1:0]     ST_DONE  = 2'd2;

    // Word index: 0..6 parameters, 7 START=1, 8 START=0
    localparam int unsigned    INDEX_W    = 4;
    localparam logic [3:0]     LAST_INDEX = 4'd8;

    // Built-in self-test preset values
    localparam logic [PIO_DATA_W-1:0] PRESET_K1 = 18'h10000;
    localparam logic [PIO_DATA_W-1:0] PRESET_K2 = 18'h10000;
    localparam logic [PIO_DATA_W-1:0] PRESET_KM = 18'h10000;
    localparam logic [PIO_DATA_W-1:0] PRESET_X1 = 18'h3C000;
    localparam logic [PIO_DATA_W-1:0] PRESET_V1 = 18'h38000;
    localparam logic [PIO_DATA_W-1:0] PRESET_X2 = 18'h0E800;
    localparam logic [PIO_DATA_W-1:0] PRESET_V2 = 18'h06800;

    // Build a protocol word from address and data
    function automatic logic [PIO_WORD_W-1:0] pack_word(
        input logic [PIO_ADDR_W-1:0] addr,
        input logic [PIO_DATA_W-1:0] data
    );
        return {addr, {PIO_PAD_W{1'b0}}, data};
    endfunction

endpackage

// File: rtl/pio_init_sequencer_hold_timer.sv
// pio_hold_timer: 8-bit hold counter for the init sequencer.
// Counts 0..HOLD_CYCLES-1 while enabled and wraps to 0 on its own.
//   clk, reset_n : clock, async active-low reset
//   clear        : force count to 0 (priority over enable)
//   enable       : advance the count
//   tc_c         : combinational terminal-count pulse (enable && count==HOLD_CYCLES-1)
module pio_hold_timer #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tc_c
);

    localparam int unsigned CNT_W  = 8;
    localparam logic [7:0]  TC_VAL = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] count_q;

    assign tc_c = enable && !clear && (count_q == TC_VAL);

    // Hold counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= tc_c ? '0 : count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pio_init_sequencer.sv
// pio_init_sequencer: transmits the seven DDA initial values plus a
// START=1 / START=0 restart handshake as addressed 32-bit words, each held
// for HOLD_CYCLES cycles with no gaps.
//   clk, reset_n   : clock, async active-low reset
//   go             : start request, honoured only in IDLE
//   preset_sel     : (PIO_INIT_PRESET_EN only) latch built-in presets instead of inputs
//   k1_in..v2_in   : parameter values, latched when go is accepted
//   pio_word_out   : registered protocol word
//   busy           : registered, high while words are being emitted
//   done           : registered, one-cycle completion pulse
// Optional feature macro: PIO_INIT_PRESET_EN
module pio_init_sequencer
    import pio_init_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned DATA_W      = 18
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              go,
`ifdef PIO_INIT_PRESET_EN
    input  logic              preset_sel,
`endif
    input  logic [DATA_W-1:0] k1_in,
    input  logic [DATA_W-1:0] k2_in,
    input  logic [DATA_W-1:0] km_in,
    input  logic [DATA_W-1:0] x1_in,
    input  logic [DATA_W-1:0] v1_in,
    input  logic [DATA_W-1:0] x2_in,
    input  logic [DATA_W-1:0] v2_in,
    output logic [31:0]       pio_word_out,
    output logic              busy,
    output logic              done
);

    localparam int unsigned NUM_VALS = 7;

    logic [STATE_W-1:0]    state_q, state_d;
    logic [INDEX_W-1:0]    index_q, index_d;
    logic [DATA_W-1:0]     val_q [NUM_VALS];
    logic [DATA_W-1:0]     val_d [NUM_VALS];
    logic [31:0]           word_d;
    logic                  busy_d;
    logic                  done_d;

    logic                  timer_clr_c;
    logic                  timer_en_c;
    logic                  timer_tc_c;
    logic                  use_preset_c;

    logic [PIO_ADDR_W-1:0] sel_addr_c;
    logic [PIO_DATA_W-1:0] sel_data_c;

    pio_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (timer_clr_c),
        .enable  (timer_en_c),
        .tc_c    (timer_tc_c)
    );

`ifdef PIO_INIT_PRESET_EN
    assign use_preset_c = preset_sel;
`else
    assign use_preset_c = 1'b0;
`endif

    // Address/data for the current word index
    always_comb begin
        sel_addr_c = ADDR_IDLE;
        sel_data_c = '0;
        case (index_q)
            4'd0: begin sel_addr_c = ADDR_K1;    sel_data_c = PIO_DATA_W'(val_q[0]); end
            4'd1: begin sel_addr_c = ADDR_K2;    sel_data_c = PIO_DATA_W'(val_q[1]); end
            4'd2: begin sel_addr_c = ADDR_KM;    sel_data_c = PIO_DATA_W'(val_q[2]); end
            4'd3: begin sel_addr_c = ADDR_X1;    sel_data_c = PIO_DATA_W'(val_q[3]); end
            4'd4: begin sel_addr_c = ADDR_V1;    sel_data_c = PIO_DATA_W'(val_q[4]); end
            4'd5: begin sel_addr_c = ADDR_X2;    sel_data_c = PIO_DATA_W'(val_q[5]); end
            4'd6: begin sel_addr_c = ADDR_V2;    sel_data_c = PIO_DATA_W'(val_q[6]); end
            4'd7: begin sel_addr_c = ADDR_START; sel_data_c = PIO_DATA_W'(1); end
            4'd8: begin sel_addr_c = ADDR_START; sel_data_c = '0; end
            default: begin sel_addr_c = ADDR_IDLE; sel_data_c = '0; end
        endcase
    end

    // Next-state and registered-output logic. Outputs follow the current
    // state, so each word appears one cycle after its state/index is entered.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        val_d       = val_q;
        word_d      = '0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        timer_clr_c = 1'b1;
        timer_en_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                index_d = '0;
                if (go) begin
                    state_d = ST_SEND;
                    if (use_preset_c) begin
                        val_d[0] = DATA_W'(PRESET_K1);
                        val_d[1] = DATA_W'(PRESET_K2);
                        val_d[2] = DATA_W'(PRESET_KM);
                        val_d[3] = DATA_W'(PRESET_X1);
                        val_d[4] = DATA_W'(PRESET_V1);
                        val_d[5] = DATA_W'(PRESET_X2);
                        val_d[6] = DATA_W'(PRESET_V2);
                    end else begin
                        val_d[0] = k1_in;
                        val_d[1] = k2_in;
                        val_d[2] = km_in;
                        val_d[3] = x1_in;
                        val_d[4] = v1_in;
                        val_d[5] = x2_in;
                        val_d[6] = v2_in;
                    end
                end
            end

            ST_SEND: begin
                if (index_q > LAST_INDEX) begin
                    // Corrupted index: abandon the run
                    state_d = ST_IDLE;
                    index_d = '0;
                end else begin
                    timer_clr_c = 1'b0;
                    timer_en_c  = 1'b1;
                    busy_d      = 1'b1;
                    word_d      = pack_word(sel_addr_c, sel_data_c);
                    if (timer_tc_c) begin
                        if (index_q == LAST_INDEX) begin
                            state_d = ST_DONE;
                            index_d = '0;
                        end else begin
                            index_d = index_q + INDEX_W'(1);
                        end
                    end
                end
            end

            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                index_d = '0;
            end

            default: begin
                state_d = ST_IDLE;
                index_d = '0;
            end
        endcase
    end

    // State, latched values and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            index_q      <= '0;
            pio_word_out <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            for (int i = 0; i < NUM_VALS; i++) begin
                val_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            pio_word_out <= word_d;
            busy         <= busy_d;
            done         <= done_d;
            for (int i = 0; i < NUM_VALS; i++) begin
                val_q[i] <= val_d[i];
            end
        end
    end

endmodule

// File: tb/tb_pio_init_sequencer.sv
// Self-checking bench for pio_init_sequencer: HOLD=4 and HOLD=1 instances,
// table-driven per-cycle expectations plus mid-run go/reset sequences.
module tb_pio_init_sequencer;

    typedef struct {
        logic [31:0] word;
        logic        busy;
        logic        done;
        int          cycles;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        go_a = 1'b0;
    logic        go_b = 1'b0;
`ifdef PIO_INIT_PRESET_EN
    logic        preset_sel = 1'b0;
`endif
    logic [17:0] k1_in = 18'd1, k2_in = 18'd2, km_in = 18'd3;
    logic [17:0] x1_in = 18'd4, v1_in = 18'd5, x2_in = 18'd6, v2_in = 18'd7;
    logic [31:0] word_a, word_b;
    logic        busy_a, busy_b, done_a, done_b;

    int          errors = 0;
    int          checks = 0;
    vec_t        tbl [11];
    logic [17:0] exp_data [7];
    logic [7:0]  addr_list [9];

    always #5 clk = ~clk;

    pio_init_sequencer #(.HOLD_CYCLES(4), .DATA_W(18)) dut_a (
        .clk(clk), .reset_n(reset_n), .go(go_a),
`ifdef PIO_INIT_PRESET_EN
        .preset_sel(preset_sel),
`endif
        .k1_in(k1_in), .k2_in(k2_in), .km_in(km_in), .x1_in(x1_in),
        .v1_in(v1_in), .x2_in(x2_in), .v2_in(v2_in),
        .pio_word_out(word_a), .busy(busy_a), .done(done_a)
    );

    pio_init_sequencer #(.HOLD_CYCLES(1), .DATA_W(18)) dut_b (
        .clk(clk), .reset_n(reset_n), .go(go_b),
`ifdef PIO_INIT_PRESET_EN
        .preset_sel(preset_sel),
`endif
        .k1_in(k1_in), .k2_in(k2_in), .km_in(km_in), .x1_in(x1_in),
        .v1_in(v1_in), .x2_in(x2_in), .v2_in(v2_in),
        .pio_word_out(word_b), .busy(busy_b), .done(done_b)
    );

    task automatic check(input string name, input bit sel_b,
                         input logic [31:0] ew, input logic eb, input logic ed);
        logic [31:0] w;
        logic        b, d;
        w = sel_b ? word_b : word_a;
        b = sel_b ? busy_b : busy_a;
        d = sel_b ? done_b : done_a;
        checks++;
        if (w !== ew || b !== eb || d !== ed) begin
            errors++;
            $display("FAIL %s: got word=%08h busy=%b done=%b, expected word=%08h busy=%b done=%b",
                     name, w, b, d, ew, eb, ed);
        end
    endtask

    function automatic void build_table(input int hold);
        for (int i = 0; i < 7; i++) begin
            tbl[i] = '{ {addr_list[i], 6'd0, exp_data[i]}, 1'b1, 1'b0, hold };
        end
        tbl[7]  = '{ 32'h0100_0001, 1'b1, 1'b0, hold };
        tbl[8]  = '{ 32'h0100_0000, 1'b1, 1'b0, hold };
        tbl[9]  = '{ 32'h0,         1'b0, 1'b1, 1 };
        tbl[10] = '{ 32'h0,         1'b0, 1'b0, 3 };
    endfunction

    // mode 0: plain run, 1: go + k1 change during X1, 2: async reset during V1
    task automatic run_seq(input bit sel_b, input int mode);
        build_table(sel_b ? 1 : 4);
        @(negedge clk);
        if (sel_b) go_b = 1'b1; else go_a = 1'b1;
        @(negedge clk);
        go_a = 1'b0;
        go_b = 1'b0;
        check("accept_cycle", sel_b, 32'h0, 1'b0, 1'b0);
        for (int e = 0; e < 11; e++) begin
            for (int c = 0; c < tbl[e].cycles; c++) begin
                @(negedge clk);
                if (mode == 2 && e == 4 && c == 1) begin
                    reset_n = 1'b0;
                    #1;
                    check("async_reset_mid_v1", sel_b, 32'h0, 1'b0, 1'b0);
                    @(negedge clk);
                    check("held_in_reset", sel_b, 32'h0, 1'b0, 1'b0);
                    reset_n = 1'b1;
                    return;
                end
                check($sformatf("vec%0d_cyc%0d", e, c), sel_b,
                      tbl[e].word, tbl[e].busy, tbl[e].done);
                if (mode == 1 && e == 3 && c == 0) begin
                    go_a  = 1'b1;
                    k1_in = 18'h155;
                end
                if (mode == 1 && e == 3 && c == 1) go_a = 1'b0;
            end
        end
    endtask

    initial begin
        addr_list = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd1, 8'd1};
        exp_data  = '{18'd1, 18'd2, 18'd3, 18'd4, 18'd5, 18'd6, 18'd7};

        repeat (2) @(negedge clk);
        check("reset_a", 1'b0, 32'h0, 1'b0, 1'b0);
        check("reset_b", 1'b1, 32'h0, 1'b0, 1'b0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_a", 1'b0, 32'h0, 1'b0, 1'b0);

        // Default run, HOLD=4
        run_seq(1'b0, 0);

        // go during X1 and k1 change: same sequence, no second run
        run_seq(1'b0, 1);
        k1_in = 18'd1;
        repeat (4) @(negedge clk);
        check("no_requeue", 1'b0, 32'h0, 1'b0, 1'b0);

        // Async reset during V1, then a fresh run from K1
        run_seq(1'b0, 2);
        @(negedge clk);
        check("post_reset_idle", 1'b0, 32'h0, 1'b0, 1'b0);
        run_seq(1'b0, 0);

        // Back-to-back words, HOLD=1
        run_seq(1'b1, 0);

`ifdef PIO_INIT_PRESET_EN
        preset_sel = 1'b1;
        exp_data = '{18'h10000, 18'h10000, 18'h10000, 18'h3C000,
                     18'h38000, 18'h0E800, 18'h06800};
        run_seq(1'b0, 0);
        preset_sel = 1'b0;
        exp_data  = '{18'd1, 18'd2, 18'd3, 18'd4, 18'd5, 18'd6, 18'd7};
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
